ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter.sv | 110 +++++++++++
 tb/tb_ram_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter that sequences single-word requests onto a 16x8 scratch RAM.
module ram_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          owner,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic          ram_cs,
  input  logic [DW-1:0] ram_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic ram_we_q, ram_we_d, ram_cs_q, ram_cs_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic busy_q, busy_d, owner_q, owner_d, last_q, last_d, win;
  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = ram_we_q;
    ram_cs_d   = ram_cs_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    owner_d    = owner_q;
    last_d     = last_q;
    // on a tie the port that was not served last wins
    win        = (req0 & req1) ? ~last_q : req1;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d    = ACCESS;
        owner_d    = win;
        last_d     = win;
        ram_we_d   = win ? we1 : we0;
        ram_addr_d = win ? addr1 : addr0;
        ram_din_d  = win ? wdata1 : wdata0;
        ram_cs_d   = 1'b1;
      end
      ACCESS: begin
        state_d  = ACK;
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        ack0_d   = ~owner_q;
        ack1_d   = owner_q;
        rdata0_d = (!ram_we_q && !owner_q) ? ram_dout : rdata0_q;
        rdata1_d = (!ram_we_q &&  owner_q) ? ram_dout : rdata1_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_cs_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      ram_cs_q   <= ram_cs_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
    end
  end
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;
  assign ram_cs   = ram_cs_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random traffic against a transaction-level model of the arbiter and RAM.
module tb_ram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req [2], we [2];
  logic [3:0] addr [2];
  logic [7:0] wdata [2];
  logic ack0, ack1, busy, owner, ram_we, ram_cs;
  logic [7:0] rdata0, rdata1, ram_din;
  logic [3:0] ram_addr;
  wire logic [7:0] ram_dout;
  logic [7:0] ram_mem [16];
  int checks = 0, errors = 0;
  bit rnd = 0;
  // reference model: transaction in flight, cycles left until idle
  int left;
  bit m_last, m_owner, m_we, m_cs, m_ack [2];
  logic [3:0] m_addr;
  logic [7:0] m_din, m_rdata [2], m_mem [16];

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .owner(owner), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_cs(ram_cs), .ram_dout(ram_dout)
  );

  assign ram_dout = ram_cs ? ram_mem[ram_addr] : 8'bz;
  always @(posedge clk) if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_din;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset;
    left = 0; m_last = 1; m_owner = 0; m_we = 0; m_cs = 0;
    m_addr = 0; m_din = 0;
    for (int p = 0; p < 2; p++) begin m_ack[p] = 0; m_rdata[p] = 0; end
  endtask

  task automatic model_edge;
    int w;
    m_ack[0] = 0; m_ack[1] = 0;
    if (left == 0) begin
      if (req[0] || req[1]) begin
        w = (req[0] && req[1]) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
        m_last = w[0]; m_owner = w[0];
        m_we = we[w]; m_addr = addr[w]; m_din = wdata[w]; m_cs = 1;
        left = 2;
      end
    end else if (left == 2) begin
      if (m_we) m_mem[m_addr] = m_din;
      else m_rdata[m_owner] = m_mem[m_addr];
      m_ack[m_owner] = 1; m_cs = 0; m_we = 0;
      left = 1;
    end else left = 0;
  endtask

  task automatic check_all;
    chk("ram_cs", ram_cs, m_cs);
    chk("ram_we", ram_we, m_we);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_din", ram_din, m_din);
    chk("ack0", ack0, m_ack[0]);
    chk("ack1", ack1, m_ack[1]);
    chk("rdata0", rdata0, m_rdata[0]);
    chk("rdata1", rdata1, m_rdata[1]);
    chk("busy", busy, left != 0);
    chk("owner", owner, m_owner);
  endtask

  task automatic drive_random;
    for (int p = 0; p < 2; p++) begin
      if (m_ack[p]) begin
        req[p] = $urandom_range(0, 1);
        we[p] = $urandom_range(0, 1); addr[p] = 4'($urandom); wdata[p] = 8'($urandom);
      end else if (!req[p]) begin
        req[p] = $urandom_range(0, 2) == 0;
        we[p] = $urandom_range(0, 1); addr[p] = 4'($urandom); wdata[p] = 8'($urandom);
      end else if (left == 2 && m_owner == p[0]) begin
        addr[p] = 4'($urandom); wdata[p] = 8'($urandom); we[p] = $urandom_range(0, 1);
      end
    end
  endtask

  task automatic step;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (rnd) drive_random();
  endtask

  task automatic set(input int p, input bit r, input bit w, input logic [3:0] a, input logic [7:0] d);
    req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin ram_mem[i] = 0; m_mem[i] = 0; end
    set(0, 0, 0, 0, 0); set(1, 0, 0, 0, 0);
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // write 0x0A to addr 3, then read it back
    set(0, 1, 1, 4'd3, 8'h0A);
    step(); chk("wr_cs", ram_cs, 1'b1); chk("wr_we", ram_we, 1'b1);
    step(); chk("wr_ack0", ack0, 1'b1);
    set(0, 1, 0, 4'd3, 8'h00);
    step(); chk("no_grant_in_ack", ram_cs, 1'b0);
    step(); step(); chk("rd_ack0", ack0, 1'b1); chk("rd_data0", rdata0, 8'h0A);
    set(0, 0, 0, 0, 0);
    step();
    // tie straight after reset: grants 0,1,0
    pulse_reset();
    set(0, 1, 0, 4'd3, 0); set(1, 1, 0, 4'd7, 0);
    step(); chk("tie_g0", owner, 1'b0);
    step(); step();
    step(); chk("tie_g1", owner, 1'b1);
    step(); chk("tie_rd1", ack1, 1'b1); step();
    step(); chk("tie_g2", owner, 1'b0);
    step(); step();
    // port 0 writes 0x55 to 15 while port 1 reads 15
    set(0, 1, 1, 4'd15, 8'h55); set(1, 1, 0, 4'd15, 0);
    for (int i = 0; i < 12; i++) step();
    chk("rd15", rdata1, 8'h55);
    set(0, 0, 0, 0, 0); set(1, 0, 0, 0, 0);
    step(); step(); step();
    // address change during ACCESS is ignored
    set(0, 1, 1, 4'd2, 8'h33);
    step(); chk("lat_addr", ram_addr, 4'd2);
    addr[0] = 4'd9;
    step(); req[0] = 0; step();
    chk("mem2", ram_mem[2], 8'h33); chk("mem9", ram_mem[9], 8'h00);
    // reset during ACCESS of a write aborts it
    set(0, 1, 1, 4'd5, 8'hFF);
    step(); chk("pre_rst_cs", ram_cs, 1'b1);
    req[0] = 0;
    pulse_reset();
    step(); step();
    chk("mem5", ram_mem[5], 8'h00);
    set(0, 1, 0, 4'd5, 0);
    step(); step(); chk("rd5", rdata0, 8'h00);
    set(0, 0, 0, 0, 0);
    step();
    // random traffic
    rnd = 1;
    for (int i = 0; i < 400; i++) step();
    rnd = 0;
    set(0, 0, 0, 0, 0); set(1, 0, 0, 0, 0);
    step(); step(); step(); step();
    for (int i = 0; i < 16; i++) chk("final_mem", ram_mem[i], m_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
